// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command serializer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } uart_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous word FIFO; read data is the head word, valid while o_empty is low.
// Flags and count are registered, so a push when full is dropped even if a pop occurs that cycle.
module uart_cmd_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_wr_en,
  input  logic [DATA_WIDTH-1:0]              i_wr_data,
  input  logic                               i_rd_en,
  output logic [DATA_WIDTH-1:0]              o_rd_data,
  output logic                               o_full,
  output logic                               o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nxt;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)
      w_count_nxt = r_count + 1'b1;
    else if (!w_push && w_pop)
      w_count_nxt = r_count - 1'b1;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/uart_cmd_serializer.sv
// Queues words and sends each as a UART frame (LSB first, optional parity, 1/2 stop, idle gap).
// Start bit appears one cycle after a word becomes visible in the FIFO; writes while FULL are dropped.
module uart_cmd_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [PRESCALE_W-1:0]              PRESCALE,
  input  logic                               CFG_PAR_EN,
  input  logic                               CFG_PAR_TYP,
  input  logic                               CFG_STOP2,
  input  logic [3:0]                         CFG_GAP,
  input  logic [DATA_WIDTH-1:0]              WR_DATA,
  input  logic                               WR_EN,
  output logic                               FULL,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    COUNT,
  output logic                               TX_OUT,
  output logic                               BUSY,
  output logic                               FRAME_DONE
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  logic                  w_empty;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rd_data;

  uart_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_stop_cnt;
  logic [3:0]            r_gap;
  logic [3:0]            r_gap_cnt;
  logic [PRESCALE_W-1:0] r_pre;
  logic [PRESCALE_W-1:0] r_tick;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_adv;
  logic                  w_data_last;
  logic                  w_stop_last;
  logic                  w_frame_end;
  logic                  w_done_nxt;
  logic [PRESCALE_W-1:0] w_pre_in;
  logic [PRESCALE_W-1:0] w_pre_m1;
  logic [PRESCALE_W-1:0] w_tick_nxt;

  uart_cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_wr_en   (WR_EN),
    .i_wr_data (WR_DATA),
    .i_rd_en   (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (FULL),
    .o_empty   (w_empty),
    .o_count   (COUNT)
  );

  assign w_pre_in    = (PRESCALE == '0) ? PRESCALE_W'(1) : PRESCALE;
  assign w_pre_m1    = r_pre - 1'b1;
  assign w_adv       = (r_state != IDLE) && (r_tick == w_pre_m1);
  assign w_tick_nxt  = w_adv ? '0 : r_tick + 1'b1;
  assign w_data_last = (r_idx == IDX_W'(DATA_WIDTH - 1));
  assign w_stop_last = (r_stop_cnt == r_stop2);
  assign w_frame_end = w_adv && (((r_state == STOP) && w_stop_last && (r_gap == 4'd0)) ||
                                 ((r_state == GAP) && (r_gap_cnt == r_gap - 4'd1)));
  // A frame end with a word waiting launches the next start bit with no idle cycle.
  assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);

  // FRAME_DONE is registered, so it is raised one edge ahead of the last stop-bit cycle.
  always_comb begin
    w_done_nxt = 1'b0;
    case (r_state)
      DATA:    w_done_nxt = w_adv && w_data_last && !r_par_en && !r_stop2 && (r_pre == PRESCALE_W'(1));
      PARITY:  w_done_nxt = w_adv && !r_stop2 && (r_pre == PRESCALE_W'(1));
      STOP:    w_done_nxt = w_adv ? (!w_stop_last && (r_pre == PRESCALE_W'(1)))
                                  : (w_stop_last && (w_tick_nxt == w_pre_m1));
      default: w_done_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_pre      <= PRESCALE_W'(1);
      r_tick     <= '0;
      r_idx      <= '0;
      r_tx       <= LINE_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_tick <= w_tick_nxt;
      if (w_pop) begin
        r_state   <= START;
        r_tx      <= 1'b0;
        r_busy    <= 1'b1;
        r_tick    <= '0;
        r_shift   <= w_rd_data;
        r_par_bit <= (^w_rd_data) ^ (CFG_PAR_TYP == PAR_ODD);
        r_pre     <= w_pre_in;
        r_par_en  <= CFG_PAR_EN;
        r_stop2   <= CFG_STOP2;
        r_gap     <= CFG_GAP;
      end else begin
        case (r_state)
          IDLE: begin
            r_tick <= '0;
            r_busy <= 1'b0;
            r_tx   <= LINE_IDLE;
          end
          START: if (w_adv) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
          DATA: if (w_adv) begin
            if (!w_data_last) begin
              r_idx   <= r_idx + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end else if (r_par_en) begin
              r_state <= PARITY;
              r_tx    <= r_par_bit;
            end else begin
              r_state    <= STOP;
              r_stop_cnt <= 1'b0;
              r_tx       <= LINE_IDLE;
            end
          end
          PARITY: if (w_adv) begin
            r_state    <= STOP;
            r_stop_cnt <= 1'b0;
            r_tx       <= LINE_IDLE;
          end
          STOP: if (w_adv) begin
            if (!w_stop_last) begin
              r_stop_cnt <= 1'b1;
            end else if (r_gap != 4'd0) begin
              r_state   <= GAP;
              r_gap_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
          GAP: if (w_adv) begin
            if (r_gap_cnt == r_gap - 4'd1) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign TX_OUT     = r_tx;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_done;

endmodule

// File: tb/tb_uart_cmd_serializer.sv
// Bench for uart_cmd_serializer: a line monitor decodes frames and checks them against a queue of expected words.
module tb_uart_cmd_serializer;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         pre;
    logic       par_en;
    logic       par_typ;
    logic       stop2;
    int         gap_chk;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] prescale;
  logic       par_en, par_typ, stop2;
  logic [3:0] gap;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic [3:0] count;
  logic       tx, busy, done;

  logic [6:0] wr_data_b;
  logic       wr_en_b, full_b;
  logic [3:0] count_b;
  logic       tx_b, busy_b, done_b;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb_q[$];
  exp_t        cur;
  bit          m_active = 0;
  bit          m_orphan = 0;
  bit          m_unstable, m_busy_err;
  int          m_cyc, m_nbits, m_done_pos, m_done_cnt;
  int          m_idle = 0;
  logic [15:0] m_exp, m_obs;
  logic [15:0] m_last_obs = '1;

  uart_cmd_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .PRESCALE_W(6)) u_dut (
    .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .CFG_PAR_EN(par_en), .CFG_PAR_TYP(par_typ),
    .CFG_STOP2(stop2), .CFG_GAP(gap), .WR_DATA(wr_data), .WR_EN(wr_en), .FULL(full),
    .COUNT(count), .TX_OUT(tx), .BUSY(busy), .FRAME_DONE(done)
  );

  uart_cmd_serializer #(.DATA_WIDTH(7), .FIFO_DEPTH(8), .PRESCALE_W(6)) u_dut7 (
    .CLK(clk), .RST(rst_n), .PRESCALE(prescale), .CFG_PAR_EN(par_en), .CFG_PAR_TYP(par_typ),
    .CFG_STOP2(stop2), .CFG_GAP(gap), .WR_DATA(wr_data_b), .WR_EN(wr_en_b), .FULL(full_b),
    .COUNT(count_b), .TX_OUT(tx_b), .BUSY(busy_b), .FRAME_DONE(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line monitor: builds each expected frame from the popped word and its config.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0;
      m_orphan = 0;
      m_idle   = 0;
    end else begin
      if (!m_active) begin
        if (m_orphan) begin
          if (tx === 1'b1) m_orphan = 0;
        end else if (tx === 1'b0) begin
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_frame: start bit seen with nothing queued");
            m_orphan = 1;
          end else begin
            cur = sb_q.pop_front();
            if (cur.gap_chk >= 0) begin
              n_tests++;
              if (m_idle != cur.gap_chk) begin
                n_fail++;
                $display("FAIL gap_before_%02h: %0d idle cycles, required %0d", cur.data, m_idle, cur.gap_chk);
              end
            end
            m_exp = '1;
            m_exp[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_exp[1+i] = cur.data[i];
            if (cur.par_en) m_exp[9] = (^cur.data) ^ cur.par_typ;
            m_nbits    = 10 + int'(cur.par_en) + int'(cur.stop2);
            m_obs      = '1;
            m_cyc      = 0;
            m_done_pos = -1;
            m_done_cnt = 0;
            m_unstable = 0;
            m_busy_err = 0;
            m_active   = 1;
          end
        end else begin
          m_idle++;
          if (done === 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL stray_frame_done: FRAME_DONE=1 while line idle, required 0");
          end
        end
      end
      if (m_active) begin
        if (m_cyc % cur.pre == 0) m_obs[m_cyc / cur.pre] = tx;
        else if (tx !== m_obs[m_cyc / cur.pre]) m_unstable = 1;
        if (done === 1'b1) begin
          if (m_done_pos < 0) m_done_pos = m_cyc;
          m_done_cnt++;
        end
        if (busy !== 1'b1) m_busy_err = 1;
        m_cyc++;
        if (m_cyc == m_nbits * cur.pre) begin
          n_tests++;
          if (m_obs !== m_exp) begin
            n_fail++;
            $display("FAIL frame_bits_%02h: line %b, required %b (bit0 = start)", cur.data, m_obs, m_exp);
          end
          n_tests++;
          if (m_unstable) begin
            n_fail++;
            $display("FAIL bit_hold_%02h: line moved inside a bit, required steady for %0d cycles", cur.data, cur.pre);
          end
          n_tests++;
          if (m_done_cnt != 1 || m_done_pos != m_nbits * cur.pre - 1) begin
            n_fail++;
            $display("FAIL frame_done_%02h: %0d pulses, first at cycle %0d, required 1 at cycle %0d",
                     cur.data, m_done_cnt, m_done_pos, m_nbits * cur.pre - 1);
          end
          n_tests++;
          if (m_busy_err) begin
            n_fail++;
            $display("FAIL busy_in_frame_%02h: BUSY dropped during frame, required 1", cur.data);
          end
          m_last_obs = m_obs;
          m_active   = 0;
          m_idle     = 0;
        end
      end
    end
  end

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr_word(input logic [7:0] d, input bit accept, input int gap_chk);
    exp_t e;
    wr_data = d;
    wr_en   = 1'b1;
    if (accept) begin
      e.data = d; e.pre = (prescale == 6'd0) ? 1 : int'(prescale);
      e.par_en = par_en; e.par_typ = par_typ; e.stop2 = stop2; e.gap_chk = gap_chk;
      sb_q.push_back(e);
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int c = 0;
    while ((sb_q.size() != 0 || m_active || busy !== 1'b0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_drain: still busy after %0d cycles with %0d queued, required idle", name, c, sb_q.size());
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: %b, required 1", tx); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: %b, required 0", done); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: %b, required 0", full); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: %0d, required 0", count); end
    n_tests++; if (tx_b !== 1'b1 || count_b !== 4'd0 || full_b !== 1'b0)
      begin n_fail++; $display("FAIL reset_w7: tx %b count %0d full %b, required 1 0 0", tx_b, count_b, full_b); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    prescale = 6'd4; par_en = 1'b0; par_typ = PAR_EVEN; stop2 = 1'b0; gap = 4'd0;
    wr_word(8'hAA, 1, -1);
    n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL count_after_write: %0d, required 1", count); end
    n_tests++; if (tx !== 1'b1)    begin n_fail++; $display("FAIL line_before_start: %b, required 1", tx); end
    @(negedge clk);
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL count_after_pop: %0d, required 0", count); end
    n_tests++; if (tx !== 1'b0)    begin n_fail++; $display("FAIL start_bit_latency: %b, required 0", tx); end
    n_tests++; if (busy !== 1'b1)  begin n_fail++; $display("FAIL busy_at_start: %b, required 1", busy); end
    wait_drain(200, "frame_8n1");
    prescale = 6'd0;
    wr_word(8'h5C, 1, -1);
    wait_drain(100, "prescale_zero");
  endtask

  task automatic test_parity();
    prescale = 6'd3; par_en = 1'b1; par_typ = PAR_EVEN; stop2 = 1'b0; gap = 4'd0;
    wr_word(8'h07, 1, -1);
    @(negedge clk);
    par_typ = PAR_ODD;
    wait_drain(200, "parity_even");
    n_tests++; if (m_last_obs[9] !== 1'b1) begin n_fail++; $display("FAIL parity_even_bit: %b, required 1", m_last_obs[9]); end
    wr_word(8'h07, 1, -1);
    wait_drain(200, "parity_odd");
    n_tests++; if (m_last_obs[9] !== 1'b0) begin n_fail++; $display("FAIL parity_odd_bit: %b, required 0", m_last_obs[9]); end
    par_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int c = 0;
    int pulses = 0;
    prescale = 6'd2; par_en = 1'b0; stop2 = 1'b1; gap = 4'd1;
    wr_word(8'h01, 1, -1);
    wr_word(8'h03, 1, 2);
    wr_word(8'h05, 1, 2);
    wr_word(8'hCC, 1, 2);
    while (busy === 1'b1 && c < 400) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (pulses != 4 || c >= 400) begin
      n_fail++;
      $display("FAIL b2b_busy_span: %0d frames while BUSY held (%0d cycles), required 4", pulses, c);
    end
    wait_drain(100, "back_to_back");
    stop2 = 1'b0; gap = 4'd0;
  endtask

  task automatic test_overflow();
    prescale = 6'd63; par_en = 1'b0; stop2 = 1'b0; gap = 4'd0;
    wr_word(8'hE1, 1, -1);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      wr_word(8'h30 + 8'(i), i < 8, -1);
      if (i == 6) begin
        n_tests++;
        if (full !== 1'b0 || count !== 4'd7) begin
          n_fail++; $display("FAIL fill_7: full %b count %0d, required 0 7", full, count);
        end
      end
      if (i >= 7) begin
        n_tests++;
        if (full !== 1'b1 || count !== 4'd8) begin
          n_fail++; $display("FAIL fill_%0d: full %b count %0d, required 1 8", i + 1, full, count);
        end
      end
    end
    wait_drain(7000, "overflow");
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    prescale = 6'd4; par_en = 1'b0; stop2 = 1'b0; gap = 4'd0;
    wr_word(8'hA2, 1, -1);
    wr_word(8'h11, 1, -1);
    wr_word(8'h22, 1, -1);
    repeat (16) @(negedge clk);
    n_tests++; if (tx !== 1'b0) begin n_fail++; $display("FAIL data_bit3_before_reset: %b, required 0", tx); end
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    n_tests++; if (tx !== 1'b1)    begin n_fail++; $display("FAIL async_reset_tx: %b, required 1", tx); end
    n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL async_reset_count: %0d, required 0", count); end
    n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL async_reset_busy: %b, required 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL quiet_after_reset: %0d active cycles, required 0", bad); end
    wr_word(8'h3C, 1, -1);
    wait_drain(200, "after_reset");
  endtask

  task automatic test_width7();
    logic [9:0] obs;
    logic [9:0] expv;
    int c = 0;
    int dpos = -1;
    expv = 10'b1110101010;
    obs = '0;
    prescale = 6'd3; par_en = 1'b1; par_typ = PAR_ODD; stop2 = 1'b0; gap = 4'd0;
    wr_data_b = 7'h55;
    wr_en_b = 1'b1;
    @(negedge clk);
    wr_en_b = 1'b0;
    while (tx_b !== 1'b0 && c < 10) begin
      @(negedge clk);
      c++;
    end
    n_tests++; if (c >= 10) begin n_fail++; $display("FAIL w7_start: no start bit within %0d cycles", c); end
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 1) obs[k/3] = tx_b;
      if (done_b === 1'b1 && dpos < 0) dpos = k;
      @(negedge clk);
    end
    n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL w7_frame: %b, required %b (bit0 = start)", obs, expv); end
    n_tests++; if (dpos != 29) begin n_fail++; $display("FAIL w7_frame_done: cycle %0d, required 29", dpos); end
    n_tests++; if (busy_b !== 1'b0 || tx_b !== 1'b1) begin n_fail++; $display("FAIL w7_idle_after: busy %b tx %b, required 0 1", busy_b, tx_b); end
    par_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    prescale = 6'd4; par_en = 1'b0; par_typ = PAR_EVEN; stop2 = 1'b0; gap = 4'd0;
    wr_data = '0; wr_en = 1'b0; wr_data_b = '0; wr_en_b = 1'b0;
    test_reset();
    test_first_frame();
    test_parity();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_width7();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
